// File: rtl/ptp_perout_pkg.sv
// Shared types and helpers for the PTP periodic-output scheduler.
// Time values are {seconds, nanoseconds} with nanoseconds kept below one second.
package ptp_perout_pkg;

  localparam int S_W   = 48;
  localparam int NS_W  = 30;
  localparam int FNS_W = 16;

  localparam logic [NS_W-1:0] NS_PER_S = 30'd1_000_000_000;

  typedef struct packed {
    logic [S_W-1:0]  s;
    logic [NS_W-1:0] ns;
  } ptp_time_t;

  typedef enum logic [1:0] {IDLE, ARM, WAIT_RISE, HIGH} state_t;

  // A normalised ns field is below 1e9, so its upper two bits are always zero.
  function automatic ptp_time_t ts_to_time(input logic [95:0] ts);
    ptp_time_t t;
    t.s  = ts[95:48];
    t.ns = ts[45:16];
    return t;
  endfunction

  // Full-precision compare: the target carries an all-zero fractional part.
  function automatic logic time_ge(input logic [95:0] ts, input ptp_time_t t);
    return {ts[95:48], ts[47:16], ts[15:0]} >= {t.s, 2'b00, t.ns, {FNS_W{1'b0}}};
  endfunction

endpackage

// File: rtl/ptp_time_add.sv
// Combinational normalised {s, ns} adder; seconds wrap modulo 2^48.
module ptp_time_add
  import ptp_perout_pkg::*;
(
  input  ptp_time_t a,
  input  ptp_time_t b,
  output ptp_time_t sum
);

  logic [NS_W:0] ns_sum;
  logic          carry;

  always_comb begin
    ns_sum = {1'b0, a.ns} + {1'b0, b.ns};
    carry  = (ns_sum >= {1'b0, NS_PER_S});
    sum.ns = carry ? NS_W'(ns_sum - {1'b0, NS_PER_S}) : ns_sum[NS_W-1:0];
    sum.s  = a.s + b.s + S_W'(carry);
  end

endmodule

// File: rtl/ptp_perout_sched.sv
// Periodic pulse scheduler phase-locked to a 96-bit PTP time-of-day.
// Define PTP_PEROUT_COUNT_EN to add the pulse_count output.
module ptp_perout_sched
  import ptp_perout_pkg::*;
#(
  parameter logic [S_W-1:0]  OUT_START_S   = 48'd0,
  parameter logic [NS_W-1:0] OUT_START_NS  = 30'd0,
  parameter logic [S_W-1:0]  OUT_PERIOD_S  = 48'd1,
  parameter logic [NS_W-1:0] OUT_PERIOD_NS = 30'd0,
  parameter logic [S_W-1:0]  OUT_WIDTH_S   = 48'd0,
  parameter logic [NS_W-1:0] OUT_WIDTH_NS  = 30'd1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [95:0] input_ts_96,
  input  logic        input_ts_step,
  input  logic        enable,
  input  logic [95:0] input_start,
  input  logic        input_start_valid,
  input  logic [95:0] input_period,
  input  logic        input_period_valid,
  input  logic [95:0] input_width,
  input  logic        input_width_valid,
  output logic        locked,
  output logic        error,
`ifdef PTP_PEROUT_COUNT_EN
  output logic [31:0] pulse_count,
`endif
  output logic        output_pulse
);

  ptp_time_t start_reg, period_reg, width_reg;
  ptp_time_t rise_reg, rise_next;
  ptp_time_t fall_reg, fall_next;
  ptp_time_t rise_plus_width, rise_plus_period;
  state_t    state_reg, state_next;
  logic      pulse_reg, pulse_next;
  logic      locked_reg, locked_next;
  logic      error_reg, error_next;
  logic      parked_reg, parked_next;
  logic      rearm, period_zero, hit_rise, hit_miss, hit_fall;

  // Fractional and always-zero top ns bits of the config words are don't-care.
  logic unused_cfg_bits;
  assign unused_cfg_bits = ^{input_start[47:46], input_start[15:0],
                             input_period[47:46], input_period[15:0],
                             input_width[47:46], input_width[15:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_reg  <= '{s: OUT_START_S,  ns: OUT_START_NS};
      period_reg <= '{s: OUT_PERIOD_S, ns: OUT_PERIOD_NS};
      width_reg  <= '{s: OUT_WIDTH_S,  ns: OUT_WIDTH_NS};
    end else begin
      if (input_start_valid)  start_reg  <= ts_to_time(input_start);
      if (input_period_valid) period_reg <= ts_to_time(input_period);
      if (input_width_valid)  width_reg  <= ts_to_time(input_width);
    end
  end

  ptp_time_add u_add_width (
    .a   (rise_reg),
    .b   (width_reg),
    .sum (rise_plus_width)
  );

  ptp_time_add u_add_period (
    .a   (rise_reg),
    .b   (period_reg),
    .sum (rise_plus_period)
  );

  assign rearm       = input_ts_step | input_start_valid | input_period_valid | input_width_valid;
  assign period_zero = (period_reg == '0);
  assign hit_rise    = time_ge(input_ts_96, rise_reg);
  assign hit_miss    = time_ge(input_ts_96, rise_plus_width);
  assign hit_fall    = time_ge(input_ts_96, fall_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // parked_reg holds the FSM in IDLE after a zero-period arm so the error fires once.
  always_comb begin
    state_next = state_reg;
    if (!enable) begin
      state_next = IDLE;
    end else if (rearm) begin
      state_next = ARM;
    end else begin
      case (state_reg)
        IDLE:      if (!parked_reg) state_next = ARM;
        ARM:       state_next = period_zero ? IDLE : WAIT_RISE;
        WAIT_RISE: if (!hit_miss && hit_rise) state_next = HIGH;
        HIGH:      if (hit_fall) state_next = WAIT_RISE;
        default:   state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    rise_next   = rise_reg;
    fall_next   = fall_reg;
    pulse_next  = pulse_reg;
    locked_next = locked_reg;
    error_next  = 1'b0;
    parked_next = parked_reg;
    if (!enable || rearm) begin
      pulse_next  = 1'b0;
      locked_next = 1'b0;
      parked_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          pulse_next  = 1'b0;
          locked_next = 1'b0;
        end
        ARM: begin
          locked_next = 1'b0;
          if (period_zero) begin
            error_next  = 1'b1;
            parked_next = 1'b1;
          end else begin
            rise_next = start_reg;
          end
        end
        WAIT_RISE: begin
          if (hit_miss) begin
            error_next  = 1'b1;
            rise_next   = rise_plus_period;
            locked_next = 1'b0;
          end else if (hit_rise) begin
            pulse_next = 1'b1;
            fall_next  = rise_plus_width;
          end
        end
        HIGH: begin
          if (hit_fall) begin
            pulse_next  = 1'b0;
            rise_next   = rise_plus_period;
            locked_next = 1'b1;
          end
        end
        default: pulse_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_reg   <= '0;
      fall_reg   <= '0;
      pulse_reg  <= 1'b0;
      locked_reg <= 1'b0;
      error_reg  <= 1'b0;
      parked_reg <= 1'b0;
    end else begin
      rise_reg   <= rise_next;
      fall_reg   <= fall_next;
      pulse_reg  <= pulse_next;
      locked_reg <= locked_next;
      error_reg  <= error_next;
      parked_reg <= parked_next;
    end
  end

`ifdef PTP_PEROUT_COUNT_EN
  logic [31:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          count_reg <= '0;
    else if (state_next == ARM)       count_reg <= '0;
    else if (pulse_next && !pulse_reg) count_reg <= count_reg + 32'd1;
  end

  assign pulse_count = count_reg;
`endif

  assign output_pulse = pulse_reg;
  assign locked       = locked_reg;
  assign error        = error_reg;

endmodule

// File: tb/tb_ptp_perout_sched.sv
// Scoreboard bench: expected rise/fall/error events with the timestamp seen at that edge.
module tb_ptp_perout_sched;

  localparam int EV_RISE = 0;
  localparam int EV_FALL = 1;
  localparam int EV_ERR  = 2;

  typedef struct {
    int          kind;
    logic [47:0] s;
    logic [31:0] ns;
    logic        lk;
  } ev_t;

  logic        clk;
  logic        rst;
  logic [95:0] input_ts_96;
  logic        input_ts_step;
  logic        enable;
  logic [95:0] input_start;
  logic        input_start_valid;
  logic [95:0] input_period;
  logic        input_period_valid;
  logic [95:0] input_width;
  logic        input_width_valid;
  logic        locked;
  logic        error;
  logic        output_pulse;
`ifdef PTP_PEROUT_COUNT_EN
  logic [31:0] pulse_count;
`endif

  logic [47:0] ts_s;
  logic [31:0] ts_ns;
  logic [47:0] edge_s;
  logic [31:0] edge_ns;
  logic        prev_pulse;
  ev_t         exp_q[$];
  int          vectors;
  int          miscompares;

  assign input_ts_96 = {ts_s, ts_ns, 16'h0000};

  ptp_perout_sched dut (
    .clk                (clk),
    .rst                (rst),
    .input_ts_96        (input_ts_96),
    .input_ts_step      (input_ts_step),
    .enable             (enable),
    .input_start        (input_start),
    .input_start_valid  (input_start_valid),
    .input_period       (input_period),
    .input_period_valid (input_period_valid),
    .input_width        (input_width),
    .input_width_valid  (input_width_valid),
    .locked             (locked),
    .error              (error),
`ifdef PTP_PEROUT_COUNT_EN
    .pulse_count        (pulse_count),
`endif
    .output_pulse       (output_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic string kname(input int k);
    if (k == EV_RISE) return "rise";
    if (k == EV_FALL) return "fall";
    return "error";
  endfunction

  task automatic check_ev(input int kind);
    ev_t e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected_%s: got %s at %0d.%09d locked=%0b, required no event",
               kname(kind), kname(kind), edge_s, edge_ns, locked);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.s != edge_s || e.ns != edge_ns || e.lk !== locked) begin
        miscompares++;
        $display("FAIL event: got %s at %0d.%09d locked=%0b, required %s at %0d.%09d locked=%0b",
                 kname(kind), edge_s, edge_ns, locked, kname(e.kind), e.s, e.ns, e.lk);
      end else begin
        $display("ok %s at %0d.%09d locked=%0b", kname(kind), edge_s, edge_ns, locked);
      end
    end
  endtask

  // Monitor: ts captured at the active edge, outputs sampled on the falling edge.
  initial begin
    prev_pulse = 1'b0;
    forever begin
      @(posedge clk);
      edge_s  = ts_s;
      edge_ns = ts_ns;
      @(negedge clk);
      if (rst) begin
        prev_pulse = 1'b0;
      end else begin
        if (error === 1'b1) check_ev(EV_ERR);
        if (output_pulse !== prev_pulse) check_ev(output_pulse ? EV_RISE : EV_FALL);
        prev_pulse = output_pulse;
      end
    end
  end

  task automatic expect_ev(input int kind, input logic [47:0] s, input logic [31:0] ns, input logic lk);
    ev_t e;
    e.kind = kind;
    e.s    = s;
    e.ns   = ns;
    e.lk   = lk;
    exp_q.push_back(e);
  endtask

  task automatic check1(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("ok %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic advance(input int step);
    ts_ns = ts_ns + 32'(step);
    if (ts_ns >= 32'd1_000_000_000) begin
      ts_ns = ts_ns - 32'd1_000_000_000;
      ts_s  = ts_s + 48'd1;
    end
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  // Step the timestamp each cycle until every expected event has been seen.
  task automatic wait_events(input int step, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      if (exp_q.size() != 0) advance(step);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout: %0d events still pending after %0d cycles, required 0", exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  task automatic set_ts(input logic [47:0] s, input logic [31:0] ns);
    ts_s  = s;
    ts_ns = ns;
  endtask

  // Fraction bits are filled with junk: the scheduler must ignore them.
  task automatic load_cfg(input bit ld_start, input logic [47:0] st_s, input logic [29:0] st_ns,
                          input bit ld_period, input logic [47:0] pe_s, input logic [29:0] pe_ns,
                          input bit ld_width, input logic [47:0] wi_s, input logic [29:0] wi_ns);
    input_start        = {st_s, 2'b00, st_ns, 16'hABCD};
    input_period       = {pe_s, 2'b00, pe_ns, 16'h1234};
    input_width        = {wi_s, 2'b00, wi_ns, 16'hFFFF};
    input_start_valid  = ld_start;
    input_period_valid = ld_period;
    input_width_valid  = ld_width;
    tick();
    input_start_valid  = 1'b0;
    input_period_valid = 1'b0;
    input_width_valid  = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish by %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors            = 0;
    miscompares        = 0;
    rst                = 1'b0;
    enable             = 1'b0;
    input_ts_step      = 1'b0;
    input_start        = '0;
    input_period       = '0;
    input_width        = '0;
    input_start_valid  = 1'b0;
    input_period_valid = 1'b0;
    input_width_valid  = 1'b0;
    set_ts(48'd0, 32'd0);
    #1 rst = 1'b1;
    hold(3);
    check1("reset_pulse", {31'd0, output_pulse}, 32'd0);
    check1("reset_locked", {31'd0, locked}, 32'd0);
    check1("reset_error", {31'd0, error}, 32'd0);

    // Default schedule: start 0, period 1 s, width 1000 ns.
    rst    = 1'b0;
    enable = 1'b1;
    expect_ev(EV_RISE, 48'd0, 32'd0, 1'b0);
    wait_events(0, 20);
    expect_ev(EV_FALL, 48'd0, 32'd1000, 1'b1);
    wait_events(8, 300);
    set_ts(48'd0, 32'd999_999_000);
    expect_ev(EV_RISE, 48'd1, 32'd0, 1'b1);
    expect_ev(EV_FALL, 48'd1, 32'd1000, 1'b1);
    wait_events(8, 400);

    // 400 ns period, 100 ns width, start 2 s.
    set_ts(48'd1, 32'd999_999_992);
    load_cfg(1'b1, 48'd2, 30'd0, 1'b1, 48'd0, 30'd400, 1'b1, 48'd0, 30'd100);
    expect_ev(EV_RISE, 48'd2, 32'd0,   1'b0);
    expect_ev(EV_FALL, 48'd2, 32'd104, 1'b1);
    expect_ev(EV_RISE, 48'd2, 32'd400, 1'b1);
    expect_ev(EV_FALL, 48'd2, 32'd504, 1'b1);
    expect_ev(EV_RISE, 48'd2, 32'd800, 1'b1);
    expect_ev(EV_FALL, 48'd2, 32'd904, 1'b1);
    hold(3);
    wait_events(8, 300);

    // Start just before a seconds boundary: next rise carries into 3 s.
    set_ts(48'd2, 32'd999_999_792);
    load_cfg(1'b1, 48'd2, 30'd999_999_800, 1'b0, 48'd0, 30'd0, 1'b0, 48'd0, 30'd0);
    expect_ev(EV_RISE, 48'd2, 32'd999_999_800, 1'b0);
    expect_ev(EV_FALL, 48'd2, 32'd999_999_904, 1'b1);
    expect_ev(EV_RISE, 48'd3, 32'd200, 1'b1);
    expect_ev(EV_FALL, 48'd3, 32'd304, 1'b1);
    hold(3);
    wait_events(8, 200);

    // Start in the past: four... five missed pulses (0..4 s), then a rise at 5 s.
    set_ts(48'd5, 32'd0);
    for (int i = 0; i < 5; i++) expect_ev(EV_ERR, 48'd5, 32'd0, 1'b0);
    expect_ev(EV_RISE, 48'd5, 32'd0, 1'b0);
    load_cfg(1'b1, 48'd0, 30'd0, 1'b1, 48'd1, 30'd0, 1'b1, 48'd0, 30'd1000);
    wait_events(0, 30);
    expect_ev(EV_FALL, 48'd5, 32'd1000, 1'b1);
    wait_events(8, 300);
    set_ts(48'd5, 32'd999_999_992);
    expect_ev(EV_RISE, 48'd6, 32'd0, 1'b1);
    wait_events(8, 20);

    // Timestamp step backwards to 3 s while high: drop, unlock, re-arm from start 0.
    set_ts(48'd3, 32'd0);
    input_ts_step = 1'b1;
    expect_ev(EV_FALL, 48'd3, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) expect_ev(EV_ERR, 48'd3, 32'd0, 1'b0);
    expect_ev(EV_RISE, 48'd3, 32'd0, 1'b0);
    tick();
    input_ts_step = 1'b0;
    wait_events(0, 30);

    // Disable while high: output drops and nothing else happens while disabled.
    enable = 1'b0;
    expect_ev(EV_FALL, 48'd3, 32'd0, 1'b0);
    hold(5);
    wait_events(0, 5);
    enable = 1'b1;
    for (int i = 0; i < 3; i++) expect_ev(EV_ERR, 48'd3, 32'd0, 1'b0);
    expect_ev(EV_RISE, 48'd3, 32'd0, 1'b0);
    wait_events(0, 30);
    expect_ev(EV_FALL, 48'd3, 32'd1000, 1'b1);
    wait_events(8, 300);

    // Asynchronous reset in the middle of a cycle while waiting for the next rise.
    #2;
    check1("locked_before_rst", {31'd0, locked}, 32'd1);
    rst = 1'b1;
    #1;
    check1("async_rst_locked", {31'd0, locked}, 32'd0);
    check1("async_rst_pulse", {31'd0, output_pulse}, 32'd0);
    check1("async_rst_error", {31'd0, error}, 32'd0);
    enable = 1'b0;
    hold(2);
    rst = 1'b0;
    hold(1);

    // Ten 400 ns periods from 0 s, then a start reload clears the count.
    set_ts(48'd0, 32'd0);
    enable = 1'b1;
    for (int k = 0; k < 10; k++) begin
      expect_ev(EV_RISE, 48'd0, 32'(400 * k), (k != 0));
      expect_ev(EV_FALL, 48'd0, 32'(400 * k + 104), 1'b1);
    end
    load_cfg(1'b1, 48'd0, 30'd0, 1'b1, 48'd0, 30'd400, 1'b1, 48'd0, 30'd100);
    hold(3);
    wait_events(8, 600);
`ifdef PTP_PEROUT_COUNT_EN
    check1("pulse_count_10", pulse_count, 32'd10);
`endif
    set_ts(48'd0, 32'd3712);
    load_cfg(1'b1, 48'd1, 30'd0, 1'b0, 48'd0, 30'd0, 1'b0, 48'd0, 30'd0);
    hold(2);
`ifdef PTP_PEROUT_COUNT_EN
    check1("pulse_count_cleared", pulse_count, 32'd0);
`endif
    hold(2);
    check1("pending_events", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
